// File: rtl/vga_draw_pkg.sv
// Shared definitions for the VGA pixel-drawing blocks (rectangles now,
// lines and sprites later): coordinate widths, screen size, FSM encoding.
package vga_draw_pkg;

  localparam int unsigned VGA_NX       = 10;
  localparam int unsigned VGA_NY       = 9;
  localparam int unsigned VGA_COLOR_W  = 9;
  localparam int unsigned VGA_SCREEN_W = 640;
  localparam int unsigned VGA_SCREEN_H = 480;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DRAW = 2'd1,
    ST_DONE = 2'd2
  } draw_state_e;

endpackage

// File: rtl/Up_count.sv
// n-bit up counter with synchronous active-low reset; load has priority
// over count enable.
module Up_count #(
  parameter int unsigned n = 8
) (
  input  logic [n-1:0] R,
  input  logic         Clock,
  input  logic         Resetn,
  input  logic         E,
  input  logic         L,
  output logic [n-1:0] Q
);

  // Count register: reset, then load, then increment.
  always_ff @(posedge Clock) begin
    if (!Resetn)
      Q <= '0;
    else if (L)
      Q <= R;
    else if (E)
      Q <= Q + n'(1);
  end

endmodule

// File: rtl/regn.sv
// n-bit register with synchronous active-low reset and load enable.
module regn #(
  parameter int unsigned n = 9
) (
  input  logic [n-1:0] R,
  input  logic         Resetn,
  input  logic         E,
  input  logic         Clock,
  output logic [n-1:0] Q
);

  // Hold value; reset clears, E loads R.
  always_ff @(posedge Clock) begin
    if (!Resetn)
      Q <= '0;
    else if (E)
      Q <= R;
  end

endmodule

// File: rtl/vga_rect_draw.sv
// Rectangle rasteriser feeding the VGA adapter write port. Emits one pixel
// per clock in row-major order, filled or outline, clipped at the screen
// edge, with a start/busy/done handshake. All outputs decode registers only.
module vga_rect_draw
  import vga_draw_pkg::*;
#(
  parameter int unsigned nX       = VGA_NX,
  parameter int unsigned nY       = VGA_NY,
  parameter int unsigned COLOR_W  = VGA_COLOR_W,
  parameter int unsigned SCREEN_W = VGA_SCREEN_W,
  parameter int unsigned SCREEN_H = VGA_SCREEN_H
) (
  input  logic               CLOCK_50,
  input  logic               Resetn,
  input  logic               start,
  input  logic [nX-1:0]      x0,
  input  logic [nY-1:0]      y0,
  input  logic [nX-1:0]      w,
  input  logic [nY-1:0]      h,
  input  logic [COLOR_W-1:0] color,
  input  logic               outline,
  output logic               busy,
  output logic               done,
  output logic               plot,
  output logic [nX-1:0]      px,
  output logic [nY-1:0]      py,
  output logic [COLOR_W-1:0] pcolor
);

  localparam int unsigned OPW = 2*nX + 2*nY + COLOR_W + 1;
  localparam logic [nX:0] XLIM = (nX+1)'(SCREEN_W);
  localparam logic [nY:0] YLIM = (nY+1)'(SCREEN_H);

  draw_state_e state_q, state_d;

  logic [OPW-1:0]     ops_q;
  logic [nX-1:0]      x0_q, w_q;
  logic [nY-1:0]      y0_q, h_q;
  logic [COLOR_W-1:0] color_q;
  logic               outline_q;

  logic [nX-1:0]      xc_q;
  logic [nY-1:0]      yc_q;
  logic               start_acc, in_draw;
  logic               xc_last, yc_last;
  logic               xc_load, yc_load, xc_en, yc_en;
  logic [nX:0]        x_sum;
  logic [nY:0]        y_sum;
  logic               on_border;

  assign in_draw   = (state_q == ST_DRAW);
  assign start_acc = (state_q == ST_IDLE) && start;

  // Operands are captured only on acceptance, so input changes mid-draw
  // cannot disturb the rectangle being drawn.
  regn #(.n(OPW)) u_ops (
    .R      ({x0, y0, w, h, color, outline}),
    .Resetn (Resetn),
    .E      (start_acc),
    .Clock  (CLOCK_50),
    .Q      (ops_q)
  );

  assign {x0_q, y0_q, w_q, h_q, color_q, outline_q} = ops_q;

  assign xc_last = (xc_q == (w_q - nX'(1)));
  assign yc_last = (yc_q == (h_q - nY'(1)));

  // Acceptance clears both counters; at end of row XC reloads to 0 and YC
  // steps (load beats enable inside Up_count).
  assign xc_load = start_acc || (in_draw && xc_last);
  assign xc_en   = in_draw;
  assign yc_load = start_acc;
  assign yc_en   = in_draw && xc_last;

  Up_count #(.n(nX)) u_xc (
    .R      ('0),
    .Clock  (CLOCK_50),
    .Resetn (Resetn),
    .E      (xc_en),
    .L      (xc_load),
    .Q      (xc_q)
  );

  Up_count #(.n(nY)) u_yc (
    .R      ('0),
    .Clock  (CLOCK_50),
    .Resetn (Resetn),
    .E      (yc_en),
    .L      (yc_load),
    .Q      (yc_q)
  );

  // State register.
  always_ff @(posedge CLOCK_50) begin
    if (!Resetn)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  // Next-state logic and handshake outputs decoded from the state.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start)
          state_d = ((w == '0) || (h == '0)) ? ST_DONE : ST_DRAW;
      end
      ST_DRAW: begin
        busy = 1'b1;
        if (xc_last && yc_last)
          state_d = ST_DONE;
      end
      ST_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pixel address is formed one bit wide so coordinates past the last
  // column/row clip instead of wrapping back onto the screen.
  always_comb begin
    x_sum     = {1'b0, x0_q} + {1'b0, xc_q};
    y_sum     = {1'b0, y0_q} + {1'b0, yc_q};
    on_border = (xc_q == '0) || xc_last || (yc_q == '0) || yc_last;
    plot      = in_draw && (x_sum < XLIM) && (y_sum < YLIM) &&
                (!outline_q || on_border);
    px        = x_sum[nX-1:0];
    py        = y_sum[nY-1:0];
    pcolor    = color_q;
  end

endmodule

// File: tb/tb_vga_rect_draw.sv
module tb_vga_rect_draw;

  logic       CLOCK_50 = 1'b0;
  logic       Resetn   = 1'b0;
  logic       start    = 1'b0;
  logic [9:0] x0 = '0, w = '0;
  logic [8:0] y0 = '0, h = '0;
  logic [8:0] color = '0;
  logic       outline = 1'b0;
  logic       busy, done, plot;
  logic [9:0] px;
  logic [8:0] py;
  logic [8:0] pcolor;

  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
    logic [8:0] c;
  } pix_t;

  pix_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  vga_rect_draw #(.nX(10), .nY(9), .COLOR_W(9), .SCREEN_W(640), .SCREEN_H(480)) dut (
    .CLOCK_50 (CLOCK_50),
    .Resetn   (Resetn),
    .start    (start),
    .x0       (x0),
    .y0       (y0),
    .w        (w),
    .h        (h),
    .color    (color),
    .outline  (outline),
    .busy     (busy),
    .done     (done),
    .plot     (plot),
    .px       (px),
    .py       (py),
    .pcolor   (pcolor)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Scoreboard: every plotted pixel must be the next expected one.
  always @(negedge CLOCK_50) begin
    pix_t e;
    if (plot === 1'b1) begin
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_plot: got (%0d,%0d,%h) expected no plot", px, py, pcolor);
      end else begin
        e = exp_q.pop_front();
        if ({px, py, pcolor} !== e)
          $display("FAIL pixel: got (%0d,%0d,%h) expected (%0d,%0d,%h)",
                   px, py, pcolor, e.x, e.y, e.c);
        else
          n_pass++;
      end
    end
  end

  // Reference model of the rasteriser: expected plotted pixels in order.
  task automatic push_rect(input int ax, input int ay, input int aw, input int ah,
                           input logic [8:0] c, input logic ol);
    for (int yy = 0; yy < ah; yy++) begin
      for (int xx = 0; xx < aw; xx++) begin
        int x = ax + xx;
        int y = ay + yy;
        bit border = (xx == 0) || (xx == aw-1) || (yy == 0) || (yy == ah-1);
        if (x < 640 && y < 480 && (!ol || border))
          exp_q.push_back({x[9:0], y[8:0], c});
      end
    end
  endtask

  // Presents operands with start for one accepting edge.
  task automatic issue(input int ax, input int ay, input int aw, input int ah,
                       input logic [8:0] c, input logic ol);
    @(posedge CLOCK_50); #1;
    x0 = ax[9:0]; y0 = ay[8:0]; w = aw[9:0]; h = ah[8:0];
    color = c; outline = ol; start = 1'b1;
    @(posedge CLOCK_50); #1;
    start = 1'b0;
  endtask

  // Observes cycles after acceptance until done (bounded).
  task automatic measure(input int budget, output int done_cyc,
                         output int nplots, output int nbusy);
    done_cyc = -1; nplots = 0; nbusy = 0;
    for (int k = 1; k <= budget; k++) begin
      @(negedge CLOCK_50);
      if (plot === 1'b1) nplots++;
      if (busy === 1'b1) nbusy++;
      if (done === 1'b1) begin
        done_cyc = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    Resetn = 1'b0;
    repeat (2) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else n_pass++;
    n_total++; if (plot !== 1'b0) $display("FAIL reset_plot: got %b expected 0", plot); else n_pass++;
    n_total++; if (px !== 10'd0) $display("FAIL reset_px: got %0d expected 0", px); else n_pass++;
    n_total++; if (py !== 9'd0) $display("FAIL reset_py: got %0d expected 0", py); else n_pass++;
    n_total++; if (pcolor !== 9'd0) $display("FAIL reset_pcolor: got %h expected 0", pcolor); else n_pass++;
    Resetn = 1'b1;
  endtask

  task automatic test_filled();
    int d, n, b;
    push_rect(10, 20, 3, 2, 9'h1C0, 1'b0);
    issue(10, 20, 3, 2, 9'h1C0, 1'b0);
    measure(30, d, n, b);
    n_total++; if (d != 7) $display("FAIL filled_done_cycle: got %0d expected 7", d); else n_pass++;
    n_total++; if (n != 6) $display("FAIL filled_plots: got %0d expected 6", n); else n_pass++;
    n_total++; if (b != 7) $display("FAIL filled_busy_cycles: got %0d expected 7", b); else n_pass++;
    n_total++; if (exp_q.size() != 0) $display("FAIL filled_left: got %0d expected 0", exp_q.size()); else n_pass++;
    @(negedge CLOCK_50);
    n_total++; if (done !== 1'b0) $display("FAIL done_pulse_width: got %b expected 0", done); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL busy_after_done: got %b expected 0", busy); else n_pass++;
  endtask

  task automatic test_outline();
    int d, n, b;
    push_rect(100, 50, 4, 3, 9'h03F, 1'b1);
    issue(100, 50, 4, 3, 9'h03F, 1'b1);
    measure(30, d, n, b);
    n_total++; if (d != 13) $display("FAIL outline_done_cycle: got %0d expected 13", d); else n_pass++;
    n_total++; if (n != 10) $display("FAIL outline_plots: got %0d expected 10", n); else n_pass++;
    n_total++; if (exp_q.size() != 0) $display("FAIL outline_left: got %0d expected 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_clip();
    int d, n, b;
    push_rect(638, 478, 4, 4, 9'h155, 1'b0);
    issue(638, 478, 4, 4, 9'h155, 1'b0);
    measure(40, d, n, b);
    n_total++; if (d != 17) $display("FAIL clip_done_cycle: got %0d expected 17", d); else n_pass++;
    n_total++; if (n != 4) $display("FAIL clip_plots: got %0d expected 4", n); else n_pass++;
    n_total++; if (exp_q.size() != 0) $display("FAIL clip_left: got %0d expected 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_empty();
    int d, n, b;
    issue(5, 5, 0, 5, 9'h0F0, 1'b0);
    measure(10, d, n, b);
    n_total++; if (d != 1) $display("FAIL empty_w_done_cycle: got %0d expected 1", d); else n_pass++;
    n_total++; if (n != 0) $display("FAIL empty_w_plots: got %0d expected 0", n); else n_pass++;
    n_total++; if (b != 1) $display("FAIL empty_w_busy: got %0d expected 1", b); else n_pass++;
    issue(5, 5, 5, 0, 9'h0F0, 1'b0);
    measure(10, d, n, b);
    n_total++; if (d != 1) $display("FAIL empty_h_done_cycle: got %0d expected 1", d); else n_pass++;
    n_total++; if (n != 0) $display("FAIL empty_h_plots: got %0d expected 0", n); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int d1 = -1, d2 = -1, n = 0;
    logic busy6 = 1'bx;
    push_rect(200, 100, 2, 2, 9'h0AA, 1'b0);
    push_rect(300, 200, 3, 1, 9'h111, 1'b0);
    @(posedge CLOCK_50); #1;
    x0 = 10'd200; y0 = 9'd100; w = 10'd2; h = 9'd2; color = 9'h0AA; outline = 1'b0;
    start = 1'b1;
    @(posedge CLOCK_50); #1;
    // start stays high; new operands must not affect the draw in flight
    x0 = 10'd300; y0 = 9'd200; w = 10'd3; h = 9'd1; color = 9'h111;
    for (int k = 1; k <= 30; k++) begin
      @(negedge CLOCK_50);
      if (plot === 1'b1) n++;
      if (k == 6) busy6 = busy;
      if (k == 7) start = 1'b0;
      if (done === 1'b1) begin
        if (d1 < 0) d1 = k;
        else begin d2 = k; break; end
      end
    end
    start = 1'b0;
    n_total++; if (d1 != 5) $display("FAIL b2b_first_done: got %0d expected 5", d1); else n_pass++;
    n_total++; if (busy6 !== 1'b0) $display("FAIL b2b_idle_gap_busy: got %b expected 0", busy6); else n_pass++;
    n_total++; if (d2 != 10) $display("FAIL b2b_second_done: got %0d expected 10", d2); else n_pass++;
    n_total++; if (n != 7) $display("FAIL b2b_plots: got %0d expected 7", n); else n_pass++;
    n_total++; if (exp_q.size() != 0) $display("FAIL b2b_left: got %0d expected 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int np = 0, late_plots = 0, late_done = 0;
    push_rect(0, 0, 10, 10, 9'h1FF, 1'b0);
    issue(0, 0, 10, 10, 9'h1FF, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      @(negedge CLOCK_50);
      if (plot === 1'b1) np++;
      if (np == 5) break;
    end
    n_total++; if (np != 5) $display("FAIL rstmid_pre_plots: got %0d expected 5", np); else n_pass++;
    #1;
    exp_q.delete();
    Resetn = 1'b0;
    @(negedge CLOCK_50);
    n_total++; if (plot !== 1'b0) $display("FAIL rstmid_plot: got %b expected 0", plot); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b expected 0", busy); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL rstmid_done: got %b expected 0", done); else n_pass++;
    n_total++; if ({px, py, pcolor} !== '0) $display("FAIL rstmid_pixel: got (%0d,%0d,%h) expected 0", px, py, pcolor); else n_pass++;
    @(posedge CLOCK_50); #1;
    Resetn = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLOCK_50);
      if (plot === 1'b1) late_plots++;
      if (done === 1'b1) late_done++;
    end
    n_total++; if (late_plots != 0) $display("FAIL rstmid_late_plots: got %0d expected 0", late_plots); else n_pass++;
    n_total++; if (late_done != 0) $display("FAIL rstmid_late_done: got %0d expected 0", late_done); else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_filled();
    test_outline();
    test_clip();
    test_empty();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
